// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for pulse_width_meter: FSM state encoding and counter saturation helper.
package pulse_width_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_e;

    localparam int WIDTH_DEFAULT = 16;

    // All-ones value for a counter of the given width (valid up to 32 bits).
    function automatic logic [31:0] sat_max(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on synchronous reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_d};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/pulse_width_meter.sv
// Measures each high phase and the following low phase of i_data, emitting one record per period.
// Define PULSE_WIDTH_METER_SYNC_EN to pass i_data through a 2-flop synchronizer first.
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_high_count,
    output logic [WIDTH-1:0] o_low_count,
    output logic             o_overflow,
    output logic             o_dropped
);

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic sample;

`ifdef PULSE_WIDTH_METER_SYNC_EN
    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_data),
        .o_q     (sample)
    );
`else
    assign sample = i_data;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] lcnt_q, lcnt_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rec_high_q, rec_high_d;
    logic [WIDTH-1:0] rec_low_q, rec_low_d;
    logic             rec_ovf_q, rec_ovf_d;
    logic             dropped_q, dropped_d;
    logic             complete;

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        ovf_d    = ovf_q;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                // A phase already high at reset release is never measured.
                if (!sample) state_d = ARMED;
            end
            ARMED: begin
                if (sample) begin
                    state_d = HIGH;
                    hcnt_d  = ONE;
                    ovf_d   = 1'b0;
                end
            end
            HIGH: begin
                if (sample) begin
                    if (hcnt_q == SAT_MAX) ovf_d = 1'b1;
                    else                   hcnt_d = hcnt_q + ONE;
                end else begin
                    state_d = LOW;
                    lcnt_d  = ONE;
                end
            end
            LOW: begin
                if (!sample) begin
                    if (lcnt_q == SAT_MAX) ovf_d = 1'b1;
                    else                   lcnt_d = lcnt_q + ONE;
                end else begin
                    complete = 1'b1;
                    state_d  = HIGH;
                    hcnt_d   = ONE;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake: a record transfers on any edge where o_valid and i_ready are both 1.
    // A completion may reuse the slot on that same edge; otherwise it is dropped while the slot is held.
    always_comb begin
        valid_d    = valid_q && !i_ready;
        rec_high_d = rec_high_q;
        rec_low_d  = rec_low_q;
        rec_ovf_d  = rec_ovf_q;
        dropped_d  = dropped_q;
        if (complete) begin
            if (!valid_q || i_ready) begin
                valid_d    = 1'b1;
                rec_high_d = hcnt_q;
                rec_low_d  = lcnt_q;
                rec_ovf_d  = ovf_q;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            rec_high_q <= '0;
            rec_low_q  <= '0;
            rec_ovf_q  <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            lcnt_q     <= lcnt_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            rec_high_q <= rec_high_d;
            rec_low_q  <= rec_low_d;
            rec_ovf_q  <= rec_ovf_d;
            dropped_q  <= dropped_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_high_count = rec_high_q;
    assign o_low_count  = rec_low_q;
    assign o_overflow   = rec_ovf_q;
    assign o_dropped    = dropped_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter (WIDTH=4) with an expected-record queue checked on every transfer.
module tb_pulse_width_meter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_data;
    logic         i_ready;
    logic         o_valid;
    logic [W-1:0] o_high_count;
    logic [W-1:0] o_low_count;
    logic         o_overflow;
    logic         o_dropped;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W:0] exp_q[$];

    pulse_width_meter #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_high_count (o_high_count),
        .o_low_count  (o_low_count),
        .o_overflow   (o_overflow),
        .o_dropped    (o_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] mk(input int h, input int l, input bit o);
        logic [31:0] hv;
        logic [31:0] lv;
        hv = h;
        lv = l;
        return {hv[W-1:0], lv[W-1:0], o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        i_data = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_data  = 1'b0;
        tick();
        i_reset = 1'b0;
    endtask

    // Scoreboard: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (!i_reset && o_valid && i_ready) begin
            check("sb_record_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check("sb_record", {o_high_count, o_low_count, o_overflow}, exp_q.pop_front());
        end
    end

    initial begin
        i_reset = 1'b1;
        i_data  = 1'b0;
        i_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_high", o_high_count, 0);
        check("rst_low", o_low_count, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_dropped", o_dropped, 0);
        i_reset = 1'b0;

        // Basic: high 3 / low 5 periods, consumer always ready.
        i_ready = 1'b1;
        drive(0, 2);
        drive(1, 3);
        drive(0, 5);
        exp_q.push_back(mk(3, 5, 0));
        drive(1, 1);
        check("basic_latency_valid", o_valid, 1);
        check("basic_first_high", o_high_count, 3);
        check("basic_first_low", o_low_count, 5);
        drive(1, 2);
        drive(0, 5);
        exp_q.push_back(mk(3, 5, 0));
        drive(1, 3);
        drive(0, 5);
        exp_q.push_back(mk(3, 5, 0));
        drive(1, 1);
        tick();
        check("basic_drained", exp_q.size(), 0);
        check("basic_valid_clear", o_valid, 0);
        check("basic_dropped", o_dropped, 0);

        // Backpressure: first record held while later completions are dropped.
        do_reset();
        i_ready = 1'b0;
        drive(0, 2);
        drive(1, 2);
        drive(0, 2);
        drive(1, 1);
        check("bp_first_valid", o_valid, 1);
        check("bp_first_rec", {o_high_count, o_low_count, o_overflow}, mk(2, 2, 0));
        check("bp_first_nodrop", o_dropped, 0);
        drive(1, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2);
            drive(1, 2);
        end
        drive(0, 3);
        drive(1, 1);
        check("bp_held_valid", o_valid, 1);
        check("bp_held_rec", {o_high_count, o_low_count, o_overflow}, mk(2, 2, 0));
        check("bp_dropped", o_dropped, 1);
        exp_q.push_back(mk(2, 2, 0));
        i_ready = 1'b1;
        drive(1, 1);
        check("bp_xfer_clear", o_valid, 0);
        drive(0, 3);
        exp_q.push_back(mk(2, 3, 0));
        drive(1, 1);
        check("bp_next_valid", o_valid, 1);
        tick();
        check("bp_drained", exp_q.size(), 0);
        check("bp_dropped_sticky", o_dropped, 1);

        // Saturation of high, recovery, saturation of low, exact maximum without overflow.
        do_reset();
        i_ready = 1'b1;
        drive(0, 2);
        drive(1, 20);
        drive(0, 2);
        exp_q.push_back(mk(15, 2, 1));
        drive(1, 1);
        check("sat_high_ovf", o_overflow, 1);
        drive(1, 1);
        drive(0, 3);
        exp_q.push_back(mk(2, 3, 0));
        drive(1, 2);
        drive(0, 18);
        exp_q.push_back(mk(2, 15, 1));
        drive(1, 15);
        drive(0, 1);
        exp_q.push_back(mk(15, 1, 0));
        drive(1, 1);
        tick();
        check("sat_drained", exp_q.size(), 0);

        // Startup while high: the partial phase produces no record.
        do_reset();
        drive(1, 5);
        drive(0, 3);
        drive(1, 2);
        drive(0, 3);
        exp_q.push_back(mk(2, 3, 0));
        drive(1, 1);
        tick();
        check("startup_drained", exp_q.size(), 0);

        // Reset mid-operation with a pending record and a sticky drop.
        do_reset();
        i_ready = 1'b0;
        drive(0, 1);
        drive(1, 2);
        drive(0, 2);
        drive(1, 1);
        drive(0, 1);
        drive(1, 1);
        check("rstmid_pre_valid", o_valid, 1);
        check("rstmid_pre_dropped", o_dropped, 1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("rstmid_valid", o_valid, 0);
        check("rstmid_dropped", o_dropped, 0);
        check("rstmid_high", o_high_count, 0);
        i_ready = 1'b1;
        drive(1, 2);
        drive(0, 2);
        drive(1, 3);
        drive(0, 2);
        exp_q.push_back(mk(3, 2, 0));
        drive(1, 1);
        tick();
        check("rstmid_drained", exp_q.size(), 0);

        // Completion on the same edge as a transfer.
        do_reset();
        i_ready = 1'b0;
        drive(0, 1);
        drive(1, 1);
        drive(0, 1);
        exp_q.push_back(mk(1, 1, 0));
        drive(1, 1);
        drive(1, 1);
        drive(0, 1);
        i_ready = 1'b1;
        exp_q.push_back(mk(2, 1, 0));
        drive(1, 1);
        check("simul_valid", o_valid, 1);
        check("simul_rec", {o_high_count, o_low_count, o_overflow}, mk(2, 1, 0));
        check("simul_dropped", o_dropped, 0);
        drive(1, 1);
        check("simul_drained", exp_q.size(), 0);
        check("simul_valid_clear", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
